serial_adder16: RTL and testbench

Bit-serial multi-cycle adder for the 16-bit datapath. Each cycle it runs one operand bit through a full adder built from two half adders plus an OR on the carries, and keeps the running carry in a flip-flop. It sits directly downstream of the half-adder cell, which it instantiates. It serves as a low-area add/sub unit for multi-cycle ALU operations, with a start/busy/done handshake toward the control FSM.

---
 rtl/serial_adder16.sv | 153 +++++++++++++++
 tb/tb_serial_adder16.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder16.sv
// serial_adder16 -- bit-serial add/sub unit with start/busy/done handshake.
//
// One operand bit per cycle passes through a full adder built from two
// half_adder cells plus an OR on their carries; the running carry lives in a
// flip-flop. An operation takes WIDTH cycles in RUN, followed by one DONE
// cycle carrying the done pulse.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN
//   defined   -> 'sub' port present; sub=1 computes A-B (B inverted, carry seeded 1)
//   undefined -> add-only unit, no 'sub' port; timing identical
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled in IDLE/DONE
//   a, b   in   WIDTH-bit operands, sampled on the accepting edge
//   sub    in   1 = A-B, 0 = A+B (only with SERIAL_ADDER_SUB_EN)
//   busy   out  high for the WIDTH cycles of RUN
//   done   out  one-cycle pulse, result valid
//   sum    out  WIDTH-bit result, held until the next completion
//   cout   out  carry out of MSB (for sub, 1 = no borrow)
//   ovf    out  two's-complement overflow
//
// States:
//   IDLE | waiting for start
//   RUN  | shifting one bit per cycle through the full adder
//   DONE | done pulse; start here begins a back-to-back operation

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN_BIT  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  // Only the WIDTH-1 most recent result bits need storing; the newest bit
  // comes straight from the adder when the result is copied out.
  logic [WIDTH-2:0] part;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             carry_msb;

  logic             sub_eff;
  logic [WIDTH-1:0] b_eff;
  logic             s0, c0, s1, c1, c_next;
  logic [WIDTH-1:0] part_next;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  assign b_eff = sub_eff ? ~b : b;

  half_adder u_ha0 (.x(opa[0]), .y(opb[0]), .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0),     .y(carry),  .s(s1), .c(c1));

  assign c_next    = c0 | c1;
  assign part_next = {s1, part};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      part      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      carry_msb <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= a;
            opb   <= b_eff;
            carry <= sub_eff;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= c_next;
          part  <= part_next[WIDTH-1:1];
          cnt   <= cnt + 1'b1;
          // Carry out of bit WIDTH-2 is the carry into the MSB.
          if (cnt == PEN_BIT) begin
            carry_msb <= c_next;
          end
          if (cnt == LAST_BIT) begin
            sum   <= part_next;
            cout  <= c_next;
            ovf   <= carry_msb ^ c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder16.sv
// Testbench for serial_adder16 (WIDTH=16): table vectors from the test plan,
// randomized operations against an arithmetic reference model, and
// hand-written sequences for ignored restart, mid-run reset and back-to-back.
`timescale 1ns/1ps

module tb_serial_adder16;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        sub;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  serial_adder16 #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
    logic [15:0] es;
    logic        ec;
    logic        ev;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic and sign rules.
  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                output logic [15:0] rs, output logic c, output logic v);
    int ix, iy;
    ix = int'(x);
    iy = int'(y);
    if (s) begin
      rs = 16'(ix - iy);
      c  = (ix >= iy);
      v  = (x[15] != y[15]) && (rs[15] != x[15]);
    end else begin
      rs = 16'(ix + iy);
      c  = ((ix + iy) > 65535);
      v  = (x[15] == y[15]) && (rs[15] != x[15]);
    end
  endfunction

  // Present operands for one edge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [15:0] x, input logic [15:0] y, input logic s);
    @(negedge clk);
    a = x; b = y; sub = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = HAS_SUB ? 1'($urandom) : 1'b0;
  endtask

  task automatic wait_done(output int bc, output bit got);
    got = 1'b0;
    bc  = 0;
    for (int i = 0; i < 64 && !got; i++) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        if (busy === 1'b1) bc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_and_check(input string name, input logic [15:0] x, input logic [15:0] y,
                               input logic s, input logic [15:0] es, input logic ec, input logic ev);
    int bc;
    bit got;
    launch(x, y, s);
    chk({name, "_busy_start"}, 32'(busy), 32'd1);
    wait_done(bc, got);
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    chk({name, "_busy_cycles"}, 32'(bc), 32'd16);
    chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
    chk({name, "_sum"}, 32'(sum), 32'(es));
    chk({name, "_cout"}, 32'(cout), 32'(ec));
    chk({name, "_ovf"}, 32'(ovf), 32'(ev));
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int bc, cnt, t1, t2;
    bit got;
    logic [15:0] rs, rx, ry, prev;
    logic rc, rv, rsub;

    tv[0] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
    tv[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tv[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tv[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    tv[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tv[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    tv[6] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tv[7] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum",  32'(sum),  32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    chk("reset_ovf",  32'(ovf),  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (tv[i].s && !HAS_SUB) continue;
      run_and_check($sformatf("vec%0d", i), tv[i].x, tv[i].y, tv[i].s, tv[i].es, tv[i].ec, tv[i].ev);
    end

    for (int i = 0; i < 40; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (i % 8 == 0) ry = 16'hFFFF - rx;
      rsub = HAS_SUB ? 1'($urandom) : 1'b0;
      model(rx, ry, rsub, rs, rc, rv);
      run_and_check($sformatf("rand%0d", i), rx, ry, rsub, rs, rc, rv);
    end

    // Start re-pulsed mid-run with other operands must be ignored.
    run_and_check("pre_repulse", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);
    prev = sum;
    launch(16'h1111, 16'h2222, 1'b0);
    cnt = 0;
    repeat (4) begin
      if (busy === 1'b1) cnt++;
      @(negedge clk);
    end
    chk("repulse_sum_held", 32'(sum), 32'(prev));
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; sub = 1'b0;
    if (busy === 1'b1) cnt++;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, got);
    chk("repulse_done_seen", 32'(got), 32'd1);
    chk("repulse_busy_cycles", 32'(cnt + bc), 32'd16);
    chk("repulse_sum", 32'(sum), 32'h3333);
    @(negedge clk);
    chk("repulse_no_restart", 32'(busy), 32'd0);

    // Reset at RUN cycle 7 aborts everything immediately.
    launch(16'h1234, 16'h1111, 1'b0);
    repeat (6) @(negedge clk);
    chk("rst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_sum",  32'(sum),  32'd0);
    chk("rst_mid_cout", 32'(cout), 32'd0);
    chk("rst_mid_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("post_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Back-to-back: start held through the done cycle.
    launch(16'h4000, 16'h4000, 1'b0);
    wait_done(bc, got);
    chk("b2b_first_done", 32'(got), 32'd1);
    chk("b2b_first_sum", 32'(sum), 32'h8000);
    chk("b2b_first_ovf", 32'(ovf), 32'd1);
    t1 = cyc;
    start = 1'b1; a = 16'h00FF; b = 16'h0001; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_reassert", 32'(busy), 32'd1);
    chk("b2b_done_low", 32'(done), 32'd0);
    wait_done(bc, got);
    t2 = cyc;
    chk("b2b_second_done", 32'(got), 32'd1);
    chk("b2b_busy_cycles", 32'(bc), 32'd16);
    chk("b2b_spacing", 32'(t2 - t1), 32'd17);
    chk("b2b_second_sum", 32'(sum), 32'h0100);
    chk("b2b_second_cout", 32'(cout), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
